pipeline_controller_n: RTL



---
 rtl/pipeline_controller_n.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipeline_controller_n.sv
// Hazard controller for an in-order pipeline: per-stage stall/bubble masks,
// a flush sequencer with capture handshake, and stall-cycle/watchdog counters.
module pipeline_controller_n #(
  parameter int STAGES      = 6,
  parameter int PC_W        = 32,
  parameter int FLUSH_DEPTH = 4,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAGES-1:0] stall_req,
  input  logic              stall_all,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic [STAGES-1:0] flush,
  output logic              flush_valid,
  output logic [PC_W-1:0]   flush_pc_o,
  output logic              flush_ack,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout
);

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            state_reg;
  logic [STAGES-1:0] flush_reg;
  logic              flush_valid_reg;
  logic [PC_W-1:0]   flush_pc_reg;
  logic [CNT_W-1:0]  stall_cycles_reg;
  logic [CNT_W-1:0]  run_reg;
  logic [CNT_W-1:0]  run_next;
  logic              stall_timeout_reg;

  logic              in_flush;
  logic [STAGES-1:0] req_mask;
  logic [STAGES-1:0] req_or;
  logic              req_acc;
  logic [STAGES-1:0] depth_mask;
  logic              unused_req0;

  // Stage 0 (PC) never originates a stall; it only inherits from later stages.
  assign unused_req0 = stall_req[0];
  assign in_flush    = (state_reg == FLUSH);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_pc
        assign req_mask[gi] = 1'b0;
        assign bubble[gi]   = 1'b0;
      end else begin : g_body
        assign req_mask[gi] = stall_req[gi] & ~in_flush;
        assign bubble[gi]   = stall[gi-1] & ~stall[gi];
      end
      assign stall[gi]      = stall_all | req_or[gi];
      assign depth_mask[gi] = (gi < FLUSH_DEPTH);
    end
  endgenerate

  // A stall at stage j back-pressures every earlier stage.
  always_comb begin
    req_acc = 1'b0;
    req_or  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      req_acc   = req_acc | req_mask[i];
      req_or[i] = req_acc;
    end
  end

  assign flush_ack = rst_n & (state_reg == IDLE) & flush_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      flush_reg       <= '0;
      flush_valid_reg <= 1'b0;
      flush_pc_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush_req) begin
            flush_pc_reg <= flush_pc;
            if (stall_all) begin
              state_reg <= PEND;
            end else begin
              state_reg       <= FLUSH;
              flush_reg       <= depth_mask;
              flush_valid_reg <= 1'b1;
            end
          end
        end
        PEND: begin
          if (!stall_all) begin
            state_reg       <= FLUSH;
            flush_reg       <= depth_mask;
            flush_valid_reg <= 1'b1;
          end
        end
        FLUSH: begin
          // A frozen pipeline cannot consume the flush, so hold it.
          if (!stall_all) begin
            state_reg       <= IDLE;
            flush_reg       <= '0;
            flush_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg       <= IDLE;
          flush_reg       <= '0;
          flush_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // run_reg stays below or at TIMEOUT, so the increment cannot wrap.
  assign run_next = (run_reg == TIMEOUT_C) ? run_reg : run_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      stall_cycles_reg  <= '0;
      run_reg           <= '0;
      stall_timeout_reg <= 1'b0;
    end else if (stall[0]) begin
      if (stall_cycles_reg != '1) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      end
      run_reg <= run_next;
      if (run_next >= TIMEOUT_C) begin
        stall_timeout_reg <= 1'b1;
      end
    end else begin
      run_reg <= '0;
    end
  end

  assign flush         = flush_reg;
  assign flush_valid   = flush_valid_reg;
  assign flush_pc_o    = flush_pc_reg;
  assign stall_cycles  = stall_cycles_reg;
  assign stall_timeout = stall_timeout_reg;

endmodule
